arcade_input_conditioner: RTL and testbench



---
 rtl/arcade_input_conditioner.sv | 170 +++++++++++++++++
 tb/tb_arcade_input_conditioner.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_conditioner.sv
// rtl/arcade_input_conditioner.sv - keyboard/joystick merge into active-low two-player buttons with coin pulse shaping
module arcade_input_conditioner #(
  parameter int COIN_PULSE = 1000000,
  parameter int COIN_GAP   = 1000000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  output logic [1:0]  but_coin_s,
  output logic [1:0]  but_fire_s,
  output logic [1:0]  but_bomb_s,
  output logic [1:0]  but_tilt_s,
  output logic [1:0]  but_select_s,
  output logic [1:0]  but_up_s,
  output logic [1:0]  but_down_s,
  output logic [1:0]  but_left_s,
  output logic [1:0]  but_right_s
);

  localparam int K_UP1 = 0, K_DOWN1 = 1, K_LEFT1 = 2, K_RIGHT1 = 3, K_FIRE1 = 4, K_BOMB1 = 5;
  localparam int K_ST1A = 6, K_ST2A = 7, K_ST1B = 8, K_ST2B = 9, K_COINA = 10, K_COINB = 11;
  localparam int K_UP2 = 12, K_DOWN2 = 13, K_LEFT2 = 14, K_RIGHT2 = 15, K_FIRE2 = 16, K_BOMB2 = 17;
  localparam int K_TILT = 18;

  localparam logic [31:0] PULSE_LOAD = 32'(COIN_PULSE - 1);
  localparam logic [31:0] GAP_LOAD   = 32'(COIN_GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} coin_state_t;

  logic [18:0] key_q, key_d;
  logic        tog_q, tog_d;
  logic [8:0]  joy0_q, joy1_q;
  logic        coin_q, coin_d, coin_prev_q;
  coin_state_t state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  coin_out_q, coin_out_d, fire_q, fire_d, bomb_q, bomb_d, tilt_q, tilt_d;
  logic [1:0]  select_q, select_d, up_q, up_d, down_q, down_d, left_q, left_d, right_q, right_d;
  logic        unused_joy;

  assign unused_joy = ^{joystick_0[15:9], joystick_1[15:9]};

  always_comb begin
    key_d = key_q;
    tog_d = ps2_key[10];
    if (ps2_key[10] != tog_q) begin
      // Direction keys match both plain and extended (arrow) scancodes.
      case (ps2_key[7:0])
        8'h75:   key_d[K_UP1]    = ps2_key[9];
        8'h72:   key_d[K_DOWN1]  = ps2_key[9];
        8'h6B:   key_d[K_LEFT1]  = ps2_key[9];
        8'h74:   key_d[K_RIGHT1] = ps2_key[9];
        default: ;
      endcase
      if (!ps2_key[8]) begin
        case (ps2_key[7:0])
          8'h14:   key_d[K_FIRE1]  = ps2_key[9];
          8'h29:   key_d[K_BOMB1]  = ps2_key[9];
          8'h05:   key_d[K_ST1A]   = ps2_key[9];
          8'h06:   key_d[K_ST2A]   = ps2_key[9];
          8'h16:   key_d[K_ST1B]   = ps2_key[9];
          8'h1E:   key_d[K_ST2B]   = ps2_key[9];
          8'h2E:   key_d[K_COINA]  = ps2_key[9];
          8'h36:   key_d[K_COINB]  = ps2_key[9];
          8'h2D:   key_d[K_UP2]    = ps2_key[9];
          8'h2B:   key_d[K_DOWN2]  = ps2_key[9];
          8'h23:   key_d[K_LEFT2]  = ps2_key[9];
          8'h34:   key_d[K_RIGHT2] = ps2_key[9];
          8'h1C:   key_d[K_FIRE2]  = ps2_key[9];
          8'h1B:   key_d[K_BOMB2]  = ps2_key[9];
          8'h2C:   key_d[K_TILT]   = ps2_key[9];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    right_d  = ~{key_q[K_RIGHT2] | joy1_q[0], key_q[K_RIGHT1] | joy0_q[0]};
    left_d   = ~{key_q[K_LEFT2]  | joy1_q[1], key_q[K_LEFT1]  | joy0_q[1]};
    down_d   = ~{key_q[K_DOWN2]  | joy1_q[2], key_q[K_DOWN1]  | joy0_q[2]};
    up_d     = ~{key_q[K_UP2]    | joy1_q[3], key_q[K_UP1]    | joy0_q[3]};
    fire_d   = ~{key_q[K_FIRE2]  | joy1_q[4], key_q[K_FIRE1]  | joy0_q[4]};
    bomb_d   = ~{key_q[K_BOMB2]  | joy1_q[5], key_q[K_BOMB1]  | joy0_q[5]};
    select_d = ~{key_q[K_ST2A] | key_q[K_ST2B] | joy0_q[7] | joy1_q[7],
                 key_q[K_ST1A] | key_q[K_ST1B] | joy0_q[6] | joy1_q[6]};
    tilt_d   = {1'b1, ~key_q[K_TILT]};
    coin_d   = key_q[K_COINA] | key_q[K_COINB] | joy0_q[8] | joy1_q[8];
  end

  // Edges arriving outside IDLE are dropped, so a held request credits once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (coin_q && !coin_prev_q) begin
          state_d = S_PULSE;
          cnt_d   = PULSE_LOAD;
        end
      end
      S_PULSE: begin
        if (cnt_q == 32'd0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 32'd0) state_d = S_IDLE;
        else                cnt_d   = cnt_q - 32'd1;
      end
      default: state_d = S_IDLE;
    endcase
    coin_out_d = {1'b1, state_q != S_PULSE};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      key_q       <= '0;
      tog_q       <= ps2_key[10];
      joy0_q      <= '0;
      joy1_q      <= '0;
      coin_q      <= 1'b0;
      coin_prev_q <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      coin_out_q  <= 2'b11;
      fire_q      <= 2'b11;
      bomb_q      <= 2'b11;
      tilt_q      <= 2'b11;
      select_q    <= 2'b11;
      up_q        <= 2'b11;
      down_q      <= 2'b11;
      left_q      <= 2'b11;
      right_q     <= 2'b11;
    end else begin
      key_q       <= key_d;
      tog_q       <= tog_d;
      joy0_q      <= joystick_0[8:0];
      joy1_q      <= joystick_1[8:0];
      coin_q      <= coin_d;
      coin_prev_q <= coin_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      coin_out_q  <= coin_out_d;
      fire_q      <= fire_d;
      bomb_q      <= bomb_d;
      tilt_q      <= tilt_d;
      select_q    <= select_d;
      up_q        <= up_d;
      down_q      <= down_d;
      left_q      <= left_d;
      right_q     <= right_d;
    end
  end

  assign but_coin_s   = coin_out_q;
  assign but_fire_s   = fire_q;
  assign but_bomb_s   = bomb_q;
  assign but_tilt_s   = tilt_q;
  assign but_select_s = select_q;
  assign but_up_s     = up_q;
  assign but_down_s   = down_q;
  assign but_left_s   = left_q;
  assign but_right_s  = right_q;

endmodule

// File: tb/tb_arcade_input_conditioner.sv
// tb/tb_arcade_input_conditioner.sv - directed self-checking bench for arcade_input_conditioner
module tb_arcade_input_conditioner;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0, joystick_1;
  logic [1:0]  but_coin_s, but_fire_s, but_bomb_s, but_tilt_s, but_select_s;
  logic [1:0]  but_up_s, but_down_s, but_left_s, but_right_s;

  int total = 0;
  int bad   = 0;

  arcade_input_conditioner #(.COIN_PULSE(4), .COIN_GAP(3)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ps2_key      (ps2_key),
    .joystick_0   (joystick_0),
    .joystick_1   (joystick_1),
    .but_coin_s   (but_coin_s),
    .but_fire_s   (but_fire_s),
    .but_bomb_s   (but_bomb_s),
    .but_tilt_s   (but_tilt_s),
    .but_select_s (but_select_s),
    .but_up_s     (but_up_s),
    .but_down_s   (but_down_s),
    .but_left_s   (but_left_s),
    .but_right_s  (but_right_s)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_key(input logic pressed, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pressed, code};
  endtask

  function automatic logic [17:0] all_out();
    return {but_coin_s, but_fire_s, but_bomb_s, but_tilt_s, but_select_s,
            but_up_s, but_down_s, but_left_s, but_right_s};
  endfunction

  // Observes but_coin_s for n cycles: low samples, high-to-low transitions, and P2 coin stuck high.
  task automatic watch_coin(input int n, input logic prev_init, output int lows, output int falls,
                            output logic p2_high);
    logic prev;
    prev    = prev_init;
    lows    = 0;
    falls   = 0;
    p2_high = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (!but_coin_s[0]) lows++;
      if (prev && !but_coin_s[0]) falls++;
      if (!but_coin_s[1]) p2_high = 1'b0;
      prev = but_coin_s[0];
    end
  endtask

  task automatic wait_coin_low(output logic found);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick(1);
      if (!but_coin_s[0]) found = 1'b1;
    end
  endtask

  int   lows, falls;
  logic p2h, found;

  initial begin
    reset      = 1'b1;
    ps2_key    = 11'h400;
    joystick_0 = 16'h0000;
    joystick_1 = 16'h0000;
    tick(3);
    reset = 1'b0;
    check("reset_outputs", 32'(all_out()), 32'h3FFFF);
    tick(3);
    check("no_phantom_event", 32'(all_out()), 32'h3FFFF);

    send_key(1'b1, 9'h075);
    tick(1);
    check("up_p1_latency", 32'(but_up_s), 32'h3);
    tick(1);
    check("up_p1_press", 32'(but_up_s), 32'h2);
    send_key(1'b0, 9'h175);
    tick(2);
    check("up_p1_release_ext", 32'(but_up_s), 32'h3);

    send_key(1'b1, 9'h12D);
    tick(2);
    check("ext_exact_ignored", 32'(all_out()), 32'h3FFFF);
    send_key(1'b1, 9'h0FF);
    tick(2);
    check("unknown_ignored", 32'(all_out()), 32'h3FFFF);

    send_key(1'b1, 9'h02D);
    tick(2);
    check("up_p2_key", 32'(but_up_s), 32'h1);
    send_key(1'b0, 9'h02D);
    tick(1);
    send_key(1'b1, 9'h02C);
    tick(2);
    check("tilt_key", 32'({but_tilt_s, but_up_s}), 32'hB);
    send_key(1'b0, 9'h02C);
    tick(2);
    check("tilt_release", 32'(but_tilt_s), 32'h3);

    joystick_1 = 16'h0030;
    tick(2);
    check("joy1_fire", 32'(but_fire_s), 32'h1);
    check("joy1_bomb", 32'(but_bomb_s), 32'h1);
    joystick_0 = 16'h0010;
    tick(2);
    check("joy_both_fire", 32'(but_fire_s), 32'h0);
    joystick_0 = 16'h0000;
    joystick_1 = 16'h0040;
    tick(2);
    check("joy1_start1", 32'({but_select_s, but_fire_s}), 32'hB);

    // Same-edge keyboard fire for P1 and joystick fire for P2.
    joystick_1 = 16'h0010;
    send_key(1'b1, 9'h014);
    tick(2);
    check("key_joy_same_edge", 32'({but_fire_s, but_select_s}), 32'h3);
    send_key(1'b0, 9'h014);
    joystick_1 = 16'h0000;
    tick(2);
    check("all_released", 32'(all_out()), 32'h3FFFF);

    joystick_0 = 16'h0100;
    watch_coin(20, 1'b1, lows, falls, p2h);
    check("coin_held_width", 32'(lows), 32'd4);
    check("coin_held_one_pulse", 32'(falls), 32'd1);
    check("coin_p2_inactive", 32'(p2h), 32'd1);
    joystick_0 = 16'h0000;
    tick(10);

    send_key(1'b1, 9'h02E);
    wait_coin_low(found);
    check("coin_key_pulse", 32'(found), 32'd1);
    send_key(1'b0, 9'h02E);
    tick(1);
    send_key(1'b1, 9'h02E);
    tick(1);
    watch_coin(15, 1'b0, lows, falls, p2h);
    check("lockout_no_pulse", 32'(falls), 32'd0);
    send_key(1'b0, 9'h02E);
    tick(10);
    send_key(1'b1, 9'h036);
    watch_coin(15, 1'b1, lows, falls, p2h);
    check("post_idle_pulse", 32'(falls), 32'd1);
    check("post_idle_width", 32'(lows), 32'd4);
    send_key(1'b0, 9'h036);
    tick(10);

    joystick_0 = 16'h0100;
    wait_coin_low(found);
    check("midreset_pulse_started", 32'(found), 32'd1);
    reset = 1'b1;
    tick(1);
    check("midreset_abort", 32'(all_out()), 32'h3FFFF);
    reset = 1'b0;
    watch_coin(20, 1'b1, lows, falls, p2h);
    check("after_reset_one_pulse", 32'(falls), 32'd1);
    check("after_reset_width", 32'(lows), 32'd4);
    joystick_0 = 16'h0000;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
